eviction_write_buffer: RTL and testbench
========================================

# eviction_write_buffer

Write-back buffer between the L1 cache's physical-memory port and physical memory. It absorbs 128-bit line evictions from the cache and acknowledges them without waiting for memory. Buffered lines drain to memory in FIFO order whenever the memory port is idle. Cache line fills take priority over draining and are served from the buffer when the line is still resident.

## Interface
- DEPTH, 4, number of line entries; power of two, ≥2
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cache_read  in  1  line-fill request from cache; held until cache_resp
- cache_write  in  1  line-eviction request from cache; held until cache_resp
- cache_address  in  16  byte address; only [15:4] (line tag) is used
- cache_wdata  in  128  eviction line data
- cache_resp  out  1  one-cycle completion pulse
- cache_rdata  out  128  fill data, valid while cache_resp high
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  16  line address, [3:0] always 0
- pmem_wdata  out  128  drain data
- pmem_resp  in  1  memory completion
- pmem_rdata  in  128  memory read data

## Operation
- Entry fields: valid, tag[11:0], data[127:0]. The storage is a circular FIFO with head (oldest) and tail pointers and a count of 0..DEPTH.
- Write accept: on any edge where cache_write=1, cache_resp=0, and a slot is available, the line is stored. cache_resp is asserted in the next cycle. The slot is chosen as follows:
  - If the tag matches a valid entry that is not currently draining, that entry's data is overwritten (coalesce) and count is unchanged.
  - Otherwise the line is pushed at the tail.
  - If count==DEPTH and no coalesce is possible, the write stalls until a drain pops an entry.
- Write acceptance is independent of FSM state and may coincide with a pop. Count then nets to unchanged.
- FSM states are IDLE, FILL, DRAIN.
  - IDLE → FILL: when cache_read=1, cache_resp=0, and the tag misses the buffer. This takes priority over drain. pmem_read is asserted with pmem_address={tag,4'h0}.
  - IDLE, read hit: the youngest matching entry's data is registered and cache_resp is pulsed next cycle. The state stays IDLE.
  - IDLE → DRAIN: when count>0 and there is no pending read. pmem_write is asserted with the head entry.
  - FILL → IDLE: on pmem_resp. pmem_rdata is latched into cache_rdata and cache_resp is pulsed next cycle.
  - DRAIN → IDLE: on pmem_resp. The head entry is popped.
- A read arriving during DRAIN waits for the drain to complete; it is never reordered ahead of an in-flight write.
- pmem_read and pmem_write are never high simultaneously. Address and data on the pmem port are stable for the whole transaction.
- Requests are ignored in the cycle cache_resp is high. The requester drops or changes its request on that edge.
- Simultaneous cache_read and cache_write is illegal upstream. The block serves the read and ignores the write.

## Timing
- Reset values:
  - cache_resp, pmem_read, pmem_write = 0
  - cache_rdata, pmem_address, pmem_wdata = 0
  - all entries invalid, count=0, state IDLE
- Reset during DRAIN or FILL aborts the transaction: strobes drop the next cycle and buffered lines are discarded.
- Write accept latency: 1 cycle (request sampled at edge E, cache_resp high in cycle E+1).
- Read hit latency: 1 cycle.
- Read miss latency: pmem latency + 1 cycle. The pmem strobe rises in the cycle after the request is sampled.
- Drain starts the cycle after entering DRAIN. Back-to-back drains have one IDLE cycle between them.
- Full boundary: at count==DEPTH, a non-coalescing write is accepted on the same edge as the popping pmem_resp, and cache_resp follows next cycle.
- Pointer wrap: head and tail increment modulo DEPTH.

## Configuration
- EVICT_BUF_READ_FORWARD_EN defined: read hits are served from the buffer as above.
- Undefined: every cache_read waits in IDLE until count==0, draining the buffer first, then goes to FILL. Hit logic for reads is removed; write coalescing is retained.

## Structure
- Shared package evict_buf_pkg holds:
  - line_t (logic [127:0])
  - tag_t (logic [11:0])
  - the state enum {IDLE, FILL, DRAIN}
  - TAG_LSB=4
- Sub-module evict_buf_array holds the entry storage, valid bits, pointers, count, and the tag-match/priority logic. It outputs hit, hit index, coalesce index, and full/empty. The top-level FSM and port logic live in eviction_write_buffer.

## Test plan
- Single write then idle: write tag 0x0A3 data 0x11..11 → cache_resp at +1. pmem_write follows with pmem_address 0x0A30. After pmem_resp, count=0.
- Fill DEPTH writes with memory stalled, then a 5th distinct write → cache_resp withheld. On the first pmem_resp, the 5th write is accepted the same edge and cache_resp appears next cycle.
- Coalesce: write 0x0100 data A, then 0x0100 data B before drain → count stays 1. The drained data is B.
- Read hit (macro defined): buffer holds 0x0200 data C; read 0x0208 → cache_rdata=C at +1 with no pmem_read. Without the macro: the buffer drains, then pmem_read 0x0200.
- Read miss during drain: read 0x0300 while DRAIN is in flight → pmem_read rises only after the drain's pmem_resp. cache_rdata equals pmem_rdata.
- Reset mid-DRAIN: assert rst with pmem_write=1 → all outputs 0 next cycle, count=0, and no further pmem strobes.

Source files
------------

// File: rtl/evict_buf_pkg.sv
// Shared types and constants for the eviction write buffer.
// Contents: line/tag types, entry payload struct, FSM state enum,
// and a helper that forms a line-aligned memory address from a tag.
package evict_buf_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned LINE_W  = 128;
   localparam int unsigned TAG_LSB = 4;
   localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [TAG_W-1:0]  tag_t;

   typedef struct packed {
      tag_t  tag;
      line_t data;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN
   } state_t;

   // Line address with the byte offset forced to zero.
   function automatic logic [ADDR_W-1:0] line_addr(input tag_t tag);
      return {tag, TAG_LSB'(0)};
   endfunction

endpackage

// File: rtl/eviction_write_buffer_if.sv
// Bus bundle between the L1 cache, the eviction write buffer and memory.
// slave  : buffer view (cache requests and memory responses in).
// master : environment view (drives cache requests and memory responses).
interface eviction_write_buffer_if;
   import evict_buf_pkg::*;

   logic              cache_read;
   logic              cache_write;
   logic [ADDR_W-1:0] cache_address;
   line_t             cache_wdata;
   logic              cache_resp;
   line_t             cache_rdata;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   line_t             pmem_wdata;
   logic              pmem_resp;
   line_t             pmem_rdata;

   modport slave (
      input  cache_read, cache_write, cache_address, cache_wdata,
      input  pmem_resp, pmem_rdata,
      output cache_resp, cache_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output cache_read, cache_write, cache_address, cache_wdata,
      output pmem_resp, pmem_rdata,
      input  cache_resp, cache_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata
   );

endinterface

// File: rtl/evict_buf_array.sv
// Entry storage for the eviction write buffer: circular FIFO of lines with
// valid bits, head/tail pointers, occupancy count and tag-match logic.
// Inputs : i_push (store line, coalescing when possible), i_pop (retire head),
//          i_head_busy (head is being drained, excluded from coalescing),
//          i_wr_tag/i_wr_data, i_rd_tag.
// Outputs: read hit/index/data, coalesce hit/index, head entry, full/empty.
// Read-hit logic exists only when EVICT_BUF_READ_FORWARD_EN is defined.
module evict_buf_array
   import evict_buf_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned IW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_head_busy,
   input  tag_t          i_wr_tag,
   input  line_t         i_wr_data,
   input  tag_t          i_rd_tag,
   output logic          o_hit_c,
   output logic [IW-1:0] o_hit_idx_c,
   output line_t         o_hit_data_c,
   output logic          o_coal_c,
   output logic [IW-1:0] o_coal_idx_c,
   output tag_t          o_head_tag_c,
   output line_t         o_head_data_c,
   output logic          o_full_c,
   output logic          o_empty_c
);

   entry_t           r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [IW-1:0]    r_head;
   logic [IW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic [IW-1:0]    w_idx;
   logic [IW-1:0]    w_wr_idx;
   logic             w_alloc;

`ifndef EVICT_BUF_READ_FORWARD_EN
   logic w_unused_rd;
   assign w_unused_rd = ^i_rd_tag;
`endif

   // Scan oldest to youngest so the youngest match wins.
   always_comb begin
      o_hit_c      = 1'b0;
      o_hit_idx_c  = '0;
      o_coal_c     = 1'b0;
      o_coal_idx_c = '0;
      w_idx        = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         w_idx = r_head + IW'(k);
`ifdef EVICT_BUF_READ_FORWARD_EN
         if (r_valid[w_idx] && r_mem[w_idx].tag == i_rd_tag) begin
            o_hit_c     = 1'b1;
            o_hit_idx_c = w_idx;
         end
`endif
         if (r_valid[w_idx] && r_mem[w_idx].tag == i_wr_tag &&
             !(i_head_busy && k == 0)) begin
            o_coal_c     = 1'b1;
            o_coal_idx_c = w_idx;
         end
      end
   end

   assign o_hit_data_c  = r_mem[o_hit_idx_c].data;
   assign o_head_tag_c  = r_mem[r_head].tag;
   assign o_head_data_c = r_mem[r_head].data;
   assign o_full_c      = (r_count == CW'(DEPTH));
   assign o_empty_c     = (r_count == '0);
   assign w_alloc       = i_push && !o_coal_c;
   assign w_wr_idx      = o_coal_c ? o_coal_idx_c : r_tail;

   // Pointers, valid bits, count. Push after pop so a full-buffer
   // push into the slot being freed leaves it valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + IW'(1);
         end
         if (w_alloc) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + IW'(1);
         end
         case ({w_alloc, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Line payload; validity is tracked separately so no reset is needed.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[w_wr_idx] <= '{tag: i_wr_tag, data: i_wr_data};
      end
   end

endmodule

// File: rtl/eviction_write_buffer.sv
// Write-back buffer between the L1 cache memory port and physical memory.
// Evictions are acknowledged immediately and drained to memory in FIFO
// order when the memory port is idle; line fills take priority over drains.
// Ports: clk, rst (sync, active-high), bus (eviction_write_buffer_if.slave):
//   cache_read/write/address/wdata in, cache_resp/rdata out,
//   pmem_read/write/address/wdata out, pmem_resp/rdata in.
// Build option EVICT_BUF_READ_FORWARD_EN: serve read hits from the buffer.
// Without it, a read first drains the whole buffer and then fills.
module eviction_write_buffer
   import evict_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   eviction_write_buffer_if.slave  bus
);

   localparam int unsigned IW = $clog2(DEPTH);

   state_t            r_state;
   logic              r_cache_resp;
   line_t             r_cache_rdata;
   logic              r_pmem_read;
   logic              r_pmem_write;
   logic [ADDR_W-1:0] r_pmem_address;
   line_t             r_pmem_wdata;

   tag_t              w_tag;
   logic              w_hit;
   logic [IW-1:0]     w_hit_idx;
   line_t             w_hit_data;
   logic              w_coal;
   logic [IW-1:0]     w_coal_idx;
   tag_t              w_head_tag;
   line_t             w_head_data;
   logic              w_full;
   logic              w_empty;
   logic              w_idle;
   logic              w_rd_req;
   logic              w_wr_req;
   logic              w_pop;
   logic              w_push;
   logic              w_fill_go;
   logic              w_drain_go;
   logic              w_head_busy;
   logic              w_unused;

   assign w_tag    = bus.cache_address[ADDR_W-1:TAG_LSB];
   assign w_idle   = (r_state == IDLE);
   assign w_rd_req = bus.cache_read && !r_cache_resp;
   // A write alongside a read is dropped; the read is served.
   assign w_wr_req = bus.cache_write && !bus.cache_read && !r_cache_resp;
   assign w_pop    = (r_state == DRAIN) && bus.pmem_resp;

`ifdef EVICT_BUF_READ_FORWARD_EN
   assign w_fill_go  = w_idle && w_rd_req && !w_hit;
   assign w_drain_go = w_idle && !w_rd_req && !w_empty;
   assign w_unused   = ^{w_hit_idx, w_coal_idx, bus.cache_address[TAG_LSB-1:0]};
`else
   // A pending read lets the buffer drain completely before filling.
   assign w_fill_go  = w_idle && w_rd_req && w_empty;
   assign w_drain_go = w_idle && !w_empty;
   assign w_unused   = ^{w_hit, w_hit_idx, w_hit_data, w_coal_idx,
                         bus.cache_address[TAG_LSB-1:0]};
`endif

   // Head is latched onto the memory port on the drain-start edge too.
   assign w_head_busy = (r_state == DRAIN) || w_drain_go;
   assign w_push      = w_wr_req && (w_coal || !w_full || w_pop);

   evict_buf_array #(.DEPTH(DEPTH)) u_array (
      .clk           (clk),
      .rst           (rst),
      .i_push        (w_push),
      .i_pop         (w_pop),
      .i_head_busy   (w_head_busy),
      .i_wr_tag      (w_tag),
      .i_wr_data     (bus.cache_wdata),
      .i_rd_tag      (w_tag),
      .o_hit_c       (w_hit),
      .o_hit_idx_c   (w_hit_idx),
      .o_hit_data_c  (w_hit_data),
      .o_coal_c      (w_coal),
      .o_coal_idx_c  (w_coal_idx),
      .o_head_tag_c  (w_head_tag),
      .o_head_data_c (w_head_data),
      .o_full_c      (w_full),
      .o_empty_c     (w_empty)
   );

   // Port FSM; memory address/data held for the whole transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_cache_resp   <= 1'b0;
         r_cache_rdata  <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_pmem_address <= '0;
         r_pmem_wdata   <= '0;
      end else begin
         r_cache_resp <= w_push;
         case (r_state)
            IDLE: begin
`ifdef EVICT_BUF_READ_FORWARD_EN
               if (w_rd_req && w_hit) begin
                  r_cache_resp  <= 1'b1;
                  r_cache_rdata <= w_hit_data;
               end else
`endif
               if (w_fill_go) begin
                  r_state        <= FILL;
                  r_pmem_read    <= 1'b1;
                  r_pmem_address <= line_addr(w_tag);
               end else if (w_drain_go) begin
                  r_state        <= DRAIN;
                  r_pmem_write   <= 1'b1;
                  r_pmem_address <= line_addr(w_head_tag);
                  r_pmem_wdata   <= w_head_data;
               end
            end
            FILL: begin
               if (bus.pmem_resp) begin
                  r_state       <= IDLE;
                  r_pmem_read   <= 1'b0;
                  r_cache_resp  <= 1'b1;
                  r_cache_rdata <= bus.pmem_rdata;
               end
            end
            DRAIN: begin
               if (bus.pmem_resp) begin
                  r_state      <= IDLE;
                  r_pmem_write <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cache_resp   = r_cache_resp;
   assign bus.cache_rdata  = r_cache_rdata;
   assign bus.pmem_read    = r_pmem_read;
   assign bus.pmem_write   = r_pmem_write;
   assign bus.pmem_address = r_pmem_address;
   assign bus.pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Scoreboard bench for eviction_write_buffer: directed cache requests push
// expected cache responses and memory transactions into queues; a cache
// monitor and a memory responder pop and compare as the DUT produces them.
module tb_eviction_write_buffer;
   import evict_buf_pkg::*;

   localparam int MEM_LAT = 2;
   localparam int BOUND   = 400;

   typedef struct {
      bit    rd;
      line_t data;
   } cexp_t;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      line_t       data;
   } pexp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eviction_write_buffer_if bus();

   eviction_write_buffer #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   cexp_t cq[$];
   pexp_t pq[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    last_presp_cyc = -100;
   bit    mem_stall = 1'b0;
   int    wait_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic line_t mem_data(input logic [15:0] a);
      return {a, 16'hA5A5, ~a, 16'h5A5A, a, 16'h1234, ~a, 16'hFEDC};
   endfunction

   task automatic check_val(input string name, input logic [127:0] got,
                            input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Cache-side monitor.
   initial begin
      cexp_t ce;
      forever begin
         @(negedge clk);
         if (bus.cache_resp === 1'b1) begin
            if (cq.size() == 0) begin
               fail_now("cache_resp_unexpected", "got cache_resp, expected none");
            end else begin
               ce = cq.pop_front();
               if (ce.rd) check_val("cache_rdata", bus.cache_rdata, ce.data);
            end
         end
      end
   end

   // Memory responder and pmem-side checker.
   initial begin
      pexp_t pe;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
         end else if ((bus.pmem_read || bus.pmem_write) && !mem_stall && !rst) begin
            if (wait_cnt >= MEM_LAT) begin
               wait_cnt       = 0;
               last_presp_cyc = cyc;
               bus.pmem_rdata = mem_data(bus.pmem_address);
               bus.pmem_resp  = 1'b1;
               if (pq.size() == 0) begin
                  fail_now("pmem_unexpected", "got pmem transaction, expected none");
               end else begin
                  pe = pq.pop_front();
                  check_val("pmem_kind", {bus.pmem_write, bus.pmem_read},
                            pe.wr ? 2'b10 : 2'b01);
                  check_val("pmem_address", bus.pmem_address, pe.addr);
                  if (pe.wr) check_val("pmem_wdata", bus.pmem_wdata, pe.data);
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic cache_req(input bit rd, input logic [15:0] addr, input line_t data,
                            input int exp_lat, input string name, output int resp_cyc);
      int got;
      got      = -1;
      resp_cyc = -1;
      @(posedge clk);
      #1;
      bus.cache_read    = rd;
      bus.cache_write   = !rd;
      bus.cache_address = addr;
      bus.cache_wdata   = data;
      @(posedge clk);
      for (int c = 1; c <= BOUND; c++) begin
         @(negedge clk);
         if (bus.cache_resp === 1'b1) begin
            got      = c;
            resp_cyc = cyc;
            break;
         end
      end
      bus.cache_read  = 1'b0;
      bus.cache_write = 1'b0;
      if (got < 0) fail_now({name, "_timeout"}, "no cache_resp within bound");
      else if (exp_lat >= 0) check_val({name, "_latency"}, got, exp_lat);
   endtask

   task automatic wait_quiet(input string name);
      bit done;
      done = 1'b0;
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk);
         if (pq.size() == 0 && cq.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail_now({name, "_timeout"}, "expected traffic never completed");
      repeat (8) @(negedge clk);
   endtask

   task automatic push_w(input logic [15:0] addr, input line_t data);
      pq.push_back('{wr: 1'b1, addr: addr, data: data});
      cq.push_back('{rd: 1'b0, data: '0});
   endtask

   initial begin
      int rc;
      bit seen;
      rst               = 1'b1;
      bus.cache_read    = 1'b0;
      bus.cache_write   = 1'b0;
      bus.cache_address = '0;
      bus.cache_wdata   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_cache_resp", bus.cache_resp, 0);
      check_val("rst_pmem_read", bus.pmem_read, 0);
      check_val("rst_pmem_write", bus.pmem_write, 0);
      check_val("rst_cache_rdata", bus.cache_rdata, 0);
      check_val("rst_pmem_address", bus.pmem_address, 0);
      check_val("rst_pmem_wdata", bus.pmem_wdata, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single write, drained to 0x0A30.
      push_w(16'h0A30, {32{4'h1}});
      cache_req(1'b0, 16'h0A30, {32{4'h1}}, 1, "wr_single", rc);
      wait_quiet("wr_single");

      // Fill the buffer with memory stalled; fifth write waits for a pop.
      mem_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_w(16'h1000 + 16'(i * 256), {8{16'h2000 + 16'(i)}});
         cache_req(1'b0, 16'h1000 + 16'(i * 256), {8{16'h2000 + 16'(i)}}, 1, "wr_fill", rc);
      end
      push_w(16'h1400, {8{16'h2004}});
      seen = 1'b0;
      fork
         cache_req(1'b0, 16'h1400, {8{16'h2004}}, -1, "wr_full", rc);
         begin
            repeat (6) begin
               @(negedge clk);
               seen = seen | bus.cache_resp;
            end
            check_val("full_resp_withheld", seen, 0);
            mem_stall = 1'b0;
         end
      join
      check_val("full_accept_cycle", rc, last_presp_cyc + 1);
      wait_quiet("wr_full");

      // Coalesce behind a draining entry: only data B reaches memory.
      mem_stall = 1'b1;
      push_w(16'h0F00, {8{16'h0F0F}});
      cache_req(1'b0, 16'h0F00, {8{16'h0F0F}}, 1, "wr_coal_x", rc);
      pq.push_back('{wr: 1'b1, addr: 16'h0100, data: {32{4'hB}}});
      cq.push_back('{rd: 1'b0, data: '0});
      cache_req(1'b0, 16'h0100, {32{4'hA}}, 1, "wr_coal_a", rc);
      cq.push_back('{rd: 1'b0, data: '0});
      cache_req(1'b0, 16'h0100, {32{4'hB}}, 1, "wr_coal_b", rc);
      mem_stall = 1'b0;
      wait_quiet("coalesce");

      // Read of a buffered line.
      mem_stall = 1'b1;
      push_w(16'h0F10, {8{16'h0F1F}});
      cache_req(1'b0, 16'h0F10, {8{16'h0F1F}}, 1, "wr_hit_x", rc);
      push_w(16'h0200, {32{4'hC}});
      cache_req(1'b0, 16'h0200, {32{4'hC}}, 1, "wr_hit_c", rc);
`ifdef EVICT_BUF_READ_FORWARD_EN
      cq.push_back('{rd: 1'b1, data: {32{4'hC}}});
`else
      pq.push_back('{wr: 1'b0, addr: 16'h0200, data: '0});
      cq.push_back('{rd: 1'b1, data: mem_data(16'h0200)});
`endif
      fork
         cache_req(1'b1, 16'h0208, '0, -1, "rd_hit", rc);
         begin
            repeat (4) @(negedge clk);
            mem_stall = 1'b0;
         end
      join
`ifdef EVICT_BUF_READ_FORWARD_EN
      check_val("rd_hit_cycle", rc, last_presp_cyc + 2);
`endif
      wait_quiet("rd_hit");

      // Read miss waits behind an in-flight drain.
      mem_stall = 1'b1;
      push_w(16'h0400, {32{4'hD}});
      cache_req(1'b0, 16'h0400, {32{4'hD}}, 1, "wr_drain_d", rc);
      pq.push_back('{wr: 1'b0, addr: 16'h0300, data: '0});
      cq.push_back('{rd: 1'b1, data: mem_data(16'h0300)});
      fork
         cache_req(1'b1, 16'h0300, '0, -1, "rd_miss_drain", rc);
         begin
            repeat (4) @(negedge clk);
            mem_stall = 1'b0;
         end
      join
      wait_quiet("rd_miss_drain");

      // Read miss with an empty buffer.
      pq.push_back('{wr: 1'b0, addr: 16'h0500, data: '0});
      cq.push_back('{rd: 1'b1, data: mem_data(16'h0500)});
      cache_req(1'b1, 16'h050C, '0, MEM_LAT + 2, "rd_miss", rc);
      wait_quiet("rd_miss");

      // Reset while a drain is in flight.
      mem_stall = 1'b1;
      push_w(16'h0B00, {32{4'hE}});
      cache_req(1'b0, 16'h0B00, {32{4'hE}}, 1, "wr_rst", rc);
      for (int c = 0; c < BOUND; c++) begin
         @(negedge clk);
         if (bus.pmem_write === 1'b1) break;
      end
      check_val("rst_pre_pmem_write", bus.pmem_write, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("rst_mid_cache_resp", bus.cache_resp, 0);
      check_val("rst_mid_pmem_read", bus.pmem_read, 0);
      check_val("rst_mid_pmem_write", bus.pmem_write, 0);
      check_val("rst_mid_cache_rdata", bus.cache_rdata, 0);
      check_val("rst_mid_pmem_address", bus.pmem_address, 0);
      check_val("rst_mid_pmem_wdata", bus.pmem_wdata, 0);
      pq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      mem_stall = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | bus.pmem_read | bus.pmem_write;
      end
      check_val("rst_no_strobes", seen, 0);
      push_w(16'h0C00, {32{4'hF}});
      cache_req(1'b0, 16'h0C00, {32{4'hF}}, 1, "wr_post_rst", rc);
      wait_quiet("post_rst");

      check_val("cache_queue_empty", 128'(cq.size()), 0);
      check_val("pmem_queue_empty", 128'(pq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
